// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the VGA sync generator and the pixel-generation logic.
`timescale 1ns/1ps
interface vga_sync_gen_if #(
    parameter int CNT_W = 10
);
    logic             pix_tick;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  pix_tick,
        output hsync, vsync, video_on, x, y, line_start, frame_start
    );

    modport slave (
        output pix_tick,
        input  hsync, vsync, video_on, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-tick enabled x/y counters with horizontal and
// vertical phase FSMs driving registered sync, video-active and start strobes.
`timescale 1ns/1ps
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_FP_AT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_AT = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BP_AT   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FP_AT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_AT = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BP_AT   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    phase_t           h_state, h_next;
    phase_t           v_state, v_next;
    logic [CNT_W-1:0] x_next, y_next;
    logic             line_wrap, frame_wrap;

    always_comb begin
        x_next     = bus.x;
        y_next     = bus.y;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (bus.pix_tick) begin
            if (bus.x == H_LAST) begin
                x_next    = '0;
                line_wrap = 1'b1;
                if (bus.y == V_LAST) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = bus.y + CNT_W'(1);
                end
            end else begin
                x_next = bus.x + CNT_W'(1);
            end
        end
    end

    // Phase transitions look at the incoming position so the registered outputs
    // describe the same (x,y) as the counters with no extra pipeline stage.
    always_comb begin
        h_next = h_state;
        if (bus.pix_tick) begin
            case (h_state)
                PH_ACTIVE: if (x_next == H_FP_AT)   h_next = PH_FP;
                PH_FP:     if (x_next == H_SYNC_AT) h_next = PH_SYNC;
                PH_SYNC:   if (x_next == H_BP_AT)   h_next = PH_BP;
                PH_BP:     if (line_wrap)           h_next = PH_ACTIVE;
                default:                            h_next = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        v_next = v_state;
        if (line_wrap) begin
            case (v_state)
                PH_ACTIVE: if (y_next == V_FP_AT)   v_next = PH_FP;
                PH_FP:     if (y_next == V_SYNC_AT) v_next = PH_SYNC;
                PH_SYNC:   if (y_next == V_BP_AT)   v_next = PH_BP;
                PH_BP:     if (frame_wrap)          v_next = PH_ACTIVE;
                default:                            v_next = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_state         <= PH_ACTIVE;
            v_state         <= PH_ACTIVE;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.hsync       <= ~HS_POL;
            bus.vsync       <= ~VS_POL;
            bus.video_on    <= 1'b1;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            h_state         <= h_next;
            v_state         <= v_next;
            bus.x           <= x_next;
            bus.y           <= y_next;
            bus.hsync       <= (h_next == PH_SYNC) ? HS_POL : ~HS_POL;
            bus.vsync       <= (v_next == PH_SYNC) ? VS_POL : ~VS_POL;
            bus.video_on    <= (h_next == PH_ACTIVE) && (v_next == PH_ACTIVE);
            bus.line_start  <= line_wrap;
            bus.frame_start <= frame_wrap;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a reduced raster and a tick-count
// reference model (position = ticks since reset modulo the raster size).
`timescale 1ns/1ps
module tb_vga_sync_gen;
    localparam int   HA  = 16;
    localparam int   HFP = 4;
    localparam int   HSW = 6;
    localparam int   HBP = 6;
    localparam int   VA  = 12;
    localparam int   VFP = 2;
    localparam int   VSW = 3;
    localparam int   VBP = 3;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int   W   = 6;
    localparam int   HT  = HA + HFP + HSW + HBP;
    localparam int   VT  = VA + VFP + VSW + VBP;
    localparam int   VW  = 5 + 2 * W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   count     = 0;
    logic last_tick = 1'b0;

    vga_sync_gen_if #(.CNT_W(W)) bus ();

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .CNT_W(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] model_vec();
        int   mx, my;
        logic hs, vs, vo, ls, fs;
        mx = count % HT;
        my = (count / HT) % VT;
        hs = (mx >= HA + HFP && mx < HA + HFP + HSW) ? HSP : ~HSP;
        vs = (my >= VA + VFP && my < VA + VFP + VSW) ? VSP : ~VSP;
        vo = (mx < HA) && (my < VA);
        ls = last_tick && (mx == 0);
        fs = last_tick && (mx == 0) && (my == 0);
        return {hs, vs, vo, ls, fs, W'(mx), W'(my)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.hsync, bus.vsync, bus.video_on, bus.line_start,
                bus.frame_start, bus.x, bus.y};
    endfunction

    // One clock with the given tick; outputs are sampled 1 ns after the edge.
    task automatic step(input logic tick);
        bus.pix_tick = tick;
        @(posedge clk);
        if (reset) begin
            count     = 0;
            last_tick = 1'b0;
        end else begin
            if (tick) count = (count + 1) % (HT * VT);
            last_tick = tick;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            checks++;
            if (dut_vec() !== {~HSP, ~VSP, 1'b1, 1'b0, 1'b0, W'(0), W'(0)}) begin
                errors++;
                $display("FAIL reset_state: got %h expected %h", dut_vec(),
                         {~HSP, ~VSP, 1'b1, 1'b0, 1'b0, W'(0), W'(0)});
            end
        end
        reset = 1'b0;
    endtask

    // Tick every 4th clock through the active area and the horizontal sync pulse.
    task automatic test_hboundary();
        for (int k = 1; k <= HA + HFP + HSW; k++) begin
            for (int c = 0; c < 4; c++) begin
                step(c == 0);
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL hboundary_cycle: got %h expected %h", dut_vec(), model_vec());
                end
            end
            if (k == HA) begin
                checks++;
                if ({bus.x, bus.video_on, bus.hsync} !== {W'(HA), 1'b0, ~HSP}) begin
                    errors++;
                    $display("FAIL active_end: got %h expected %h",
                             {bus.x, bus.video_on, bus.hsync}, {W'(HA), 1'b0, ~HSP});
                end
            end
            if (k == HA + HFP) begin
                checks++;
                if (bus.hsync !== HSP) begin
                    errors++;
                    $display("FAIL hsync_start: got %b expected %b", bus.hsync, HSP);
                end
            end
            if (k == HA + HFP + HSW) begin
                checks++;
                if (bus.hsync !== ~HSP) begin
                    errors++;
                    $display("FAIL hsync_end: got %b expected %b", bus.hsync, ~HSP);
                end
            end
        end
    endtask

    task automatic test_line_wrap();
        for (int k = HA + HFP + HSW + 1; k <= HT; k++) begin
            step(1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL line_wrap_cycle: got %h expected %h", dut_vec(), model_vec());
            end
            if (k < HT) begin
                for (int c = 0; c < 3; c++) step(1'b0);
            end
        end
        checks++;
        if ({bus.x, bus.y, bus.line_start, bus.frame_start, bus.video_on} !==
            {W'(0), W'(1), 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL line_wrap: got %h expected %h",
                     {bus.x, bus.y, bus.line_start, bus.frame_start, bus.video_on},
                     {W'(0), W'(1), 1'b1, 1'b0, 1'b1});
        end
        step(1'b0);
        checks++;
        if (bus.line_start !== 1'b0) begin
            errors++;
            $display("FAIL line_start_width: got %b expected 0", bus.line_start);
        end
    endtask

    task automatic test_frame();
        int vs_cnt = 0, ls_cnt = 0, fs_cnt = 0;
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        for (int n = 1; n <= HT * VT; n++) begin
            step(1'b1);
            if (bus.vsync === VSP) vs_cnt++;
            if (bus.line_start === 1'b1) ls_cnt++;
            if (bus.frame_start === 1'b1) fs_cnt++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL frame_cycle: got %h expected %h", dut_vec(), model_vec());
            end
        end
        checks++;
        if ({bus.x, bus.y, bus.frame_start, bus.line_start} !== {W'(0), W'(0), 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL frame_wrap: got %h expected %h",
                     {bus.x, bus.y, bus.frame_start, bus.line_start}, {W'(0), W'(0), 1'b1, 1'b1});
        end
        checks++;
        if ({vs_cnt, ls_cnt, fs_cnt} !== {VSW * HT, VT, 1}) begin
            errors++;
            $display("FAIL frame_counts: got vs=%0d ls=%0d fs=%0d expected vs=%0d ls=%0d fs=1",
                     vs_cnt, ls_cnt, fs_cnt, VSW * HT, VT);
        end
        step(1'b0);
        checks++;
        if ({bus.frame_start, bus.line_start} !== 2'b00) begin
            errors++;
            $display("FAIL frame_strobe_width: got %b expected 00",
                     {bus.frame_start, bus.line_start});
        end
    endtask

    task automatic test_tick_gaps();
        int   ticks;
        logic prev_ls = 1'b0, prev_fs = 1'b0;
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        ticks = 600 + int'($urandom_range(0, 200));
        for (int n = 0; n < ticks; n++) begin
            int gap;
            gap = int'($urandom_range(1, 7));
            for (int c = 0; c <= gap; c++) begin
                step(c == gap);
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL gaps_cycle: got %h expected %h", dut_vec(), model_vec());
                end
                checks++;
                if ((prev_ls && bus.line_start) || (prev_fs && bus.frame_start)) begin
                    errors++;
                    $display("FAIL gaps_strobe_width: got ls=%b fs=%b expected single-cycle",
                             bus.line_start, bus.frame_start);
                end
                prev_ls = bus.line_start;
                prev_fs = bus.frame_start;
            end
        end
        checks++;
        if ({bus.x, bus.y} !== {W'(ticks % HT), W'((ticks / HT) % VT)}) begin
            errors++;
            $display("FAIL gaps_final_pos: got %h expected %h",
                     {bus.x, bus.y}, {W'(ticks % HT), W'((ticks / HT) % VT)});
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        for (int n = 0; n < 15 * HT + 28; n++) step(1'b1);
        checks++;
        if ({bus.x, bus.y} !== {W'(28), W'(15)}) begin
            errors++;
            $display("FAIL mid_reset_setup: got %h expected %h", {bus.x, bus.y}, {W'(28), W'(15)});
        end
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        checks++;
        if (dut_vec() !== {~HSP, ~VSP, 1'b1, 1'b0, 1'b0, W'(0), W'(0)}) begin
            errors++;
            $display("FAIL mid_reset: got %h expected %h", dut_vec(),
                     {~HSP, ~VSP, 1'b1, 1'b0, 1'b0, W'(0), W'(0)});
        end
        for (int n = 0; n < HT; n++) step(1'b1);
        checks++;
        if ({bus.x, bus.y, bus.frame_start} !== {W'(0), W'(1), 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_line: got %h expected %h",
                     {bus.x, bus.y, bus.frame_start}, {W'(0), W'(1), 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 4) != 0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL back_to_back: got %h expected %h", dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        bus.pix_tick = 1'b0;
        test_reset();
        test_hboundary();
        test_line_wrap();
        test_frame();
        test_tick_gaps();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
